// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit.
//   - CSR addresses and bit positions of the implemented fields
//   - mcause codes for the two supported interrupt sources
//   - csr_op encodings and the trap FSM state enum
//   - helpers for the CSR read-modify-write value and the trap vector
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  // mie and mip share the same layout
  localparam int IRQ_MT_BIT       = 7;
  localparam int IRQ_ME_BIT       = 11;

  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_TRAP   = 2'b01,
    ST_RETURN = 2'b10
  } trap_state_e;

  // New CSR value for a read-modify-write instruction.
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    res = old;
    case (op)
      CSR_RW:  res = wdata;
      CSR_RS:  res = old | wdata;
      CSR_RC:  res = old & ~wdata;
      default: res = old;
    endcase
    return res;
  endfunction

  // Handler address: mode 01 is vectored, every other mode is direct.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic [4:0]  cause_lo);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01) begin
      return base + {25'd0, cause_lo, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage and combinational read mux.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   csr_addr            address of the CSR being read / written
//   csr_op, csr_wdata   read-modify-write operation and operand
//   wr_en               qualified write strobe (already gated by the FSM)
//   trap_take           load mepc/mcause and stack MIE into MPIE
//   trap_pc, trap_cause values captured on trap_take
//   mret_take           restore MIE from MPIE, set MPIE
//   timer_irq, ext_irq  live interrupt lines, visible through mip
//   csr_rdata           old value of the addressed CSR
//   mstatus_mie         global interrupt enable
//   mie_mtie, mie_meie  per-source interrupt enables
//   mtvec, mepc, mcause register values for redirect computation
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  input  logic        wr_en,
  input  logic        trap_take,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_take,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        mstatus_mie,
  output logic        mie_mtie,
  output logic        mie_meie,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic [31:0] mcause
);

  logic        mstatus_mpie;
  logic [31:0] wval;

  // Read mux: only implemented fields are visible, everything else reads 0.
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
        csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      ADDR_MIE: begin
        csr_rdata[IRQ_MT_BIT] = mie_mtie;
        csr_rdata[IRQ_ME_BIT] = mie_meie;
      end
      ADDR_MTVEC:  csr_rdata = mtvec;
      ADDR_MEPC:   csr_rdata = mepc;
      ADDR_MCAUSE: csr_rdata = mcause;
      ADDR_MIP: begin
        csr_rdata[IRQ_MT_BIT] = timer_irq;
        csr_rdata[IRQ_ME_BIT] = ext_irq;
      end
      default: csr_rdata = 32'd0;
    endcase
  end

  assign wval = csr_apply(csr_op, csr_rdata, csr_wdata);

  // trap_take and mret_take are mutually exclusive with wr_en upstream;
  // the priority order here still lets a trap win if that ever changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= RESET_MTVEC;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
    end else if (trap_take) begin
      mepc         <= {trap_pc[31:2], 2'b00};
      mcause       <= trap_cause;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_take) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie  <= wval[MSTATUS_MIE_BIT];
          mstatus_mpie <= wval[MSTATUS_MPIE_BIT];
        end
        ADDR_MIE: begin
          mie_mtie <= wval[IRQ_MT_BIT];
          mie_meie <= wval[IRQ_ME_BIT];
        end
        ADDR_MTVEC:  mtvec  <= wval;
        ADDR_MEPC:   mepc   <= {wval[31:2], 2'b00};
        ADDR_MCAUSE: mcause <= wval;
        default: ;  // mip and unimplemented addresses ignore writes
      endcase
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR block with interrupt trap entry and MRET return.
// A trap or MRET decided in RUN is followed by one redirect cycle (TRAP or
// RETURN) in which csr_epc_taken/flush pulse and csr_evec holds the target.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   pc_x, instr_valid   PC of the execute/memory instruction and its valid
//   csr_op, csr_addr,
//   csr_wdata           CSR instruction (00 none, 01 RW, 10 RS, 11 RC)
//   is_mret             the instruction at pc_x is MRET
//   timer_irq, ext_irq  level-sensitive interrupt requests
//   csr_rdata           combinational old value of the addressed CSR
//   csr_epc_taken,
//   csr_evec            PC redirect request and target
//   flush               kill younger stages (same as csr_epc_taken)
//   fsm_state           current FSM state for observation
//
// Handshake: there is no backpressure. An instruction is consumed in the
// cycle instr_valid=1 while the FSM is in RUN; in TRAP/RETURN the
// instruction at pc_x is being flushed and its effects are dropped.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_x,
  input  logic        instr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        csr_epc_taken,
  output logic [31:0] csr_evec,
  output logic        flush,
  output logic [1:0]  fsm_state
);

  trap_state_e state_q, state_d;

  logic        mstatus_mie;
  logic        mie_mtie;
  logic        mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;

  logic        in_run;
  logic        ext_pend;
  logic        tmr_pend;
  logic        trap_take;
  logic        mret_take;
  logic        wr_en;
  logic [31:0] trap_cause;

  assign in_run   = (state_q == ST_RUN);
  assign ext_pend = ext_irq & mie_meie;
  assign tmr_pend = timer_irq & mie_mtie;

  // MIE is cleared on trap entry, so a level held across the redirect
  // cannot re-trap until software re-enables it.
  assign trap_take  = in_run && instr_valid && mstatus_mie && (ext_pend || tmr_pend);
  assign trap_cause = ext_pend ? CAUSE_M_EXT : CAUSE_M_TIMER;
  assign mret_take  = in_run && instr_valid && is_mret && !trap_take;
  assign wr_en      = in_run && instr_valid && (csr_op != CSR_NONE) && !trap_take;

  csr_regfile #(
    .RESET_MTVEC(RESET_MTVEC)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .wr_en       (wr_en),
    .trap_take   (trap_take),
    .trap_pc     (pc_x),
    .trap_cause  (trap_cause),
    .mret_take   (mret_take),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .mstatus_mie (mstatus_mie),
    .mie_mtie    (mie_mtie),
    .mie_meie    (mie_meie),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .mcause      (mcause)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (trap_take) begin
          state_d = ST_TRAP;
        end else if (mret_take) begin
          state_d = ST_RETURN;
        end
      end
      ST_TRAP:   state_d = ST_RUN;
      ST_RETURN: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    csr_epc_taken = 1'b0;
    csr_evec      = 32'd0;
    case (state_q)
      ST_TRAP: begin
        csr_epc_taken = 1'b1;
        csr_evec      = trap_vector(mtvec, mcause[4:0]);
      end
      ST_RETURN: begin
        csr_epc_taken = 1'b1;
        csr_evec      = mepc;
      end
      default: ;
    endcase
  end

  assign flush     = csr_epc_taken;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;
  import csr_pkg::*;

  localparam logic [31:0] RST_VEC = 32'h0000_0200;

  logic        clk;
  logic        rst;
  logic [31:0] pc_x;
  logic        instr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        csr_epc_taken;
  logic [31:0] csr_evec;
  logic        flush;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  csr_trap_unit #(
    .RESET_MTVEC(RST_VEC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_x          (pc_x),
    .instr_valid   (instr_valid),
    .csr_op        (csr_op),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .is_mret       (is_mret),
    .timer_irq     (timer_irq),
    .ext_irq       (ext_irq),
    .csr_rdata     (csr_rdata),
    .csr_epc_taken (csr_epc_taken),
    .csr_evec      (csr_evec),
    .flush         (flush),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic csr_w(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    instr_valid = 1'b1;
    csr_op      = op;
    csr_addr    = addr;
    csr_wdata   = data;
    tick();
    csr_op      = CSR_NONE;
    csr_wdata   = 32'd0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_op   = CSR_NONE;
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_old;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [11:0] a,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t r;
    r.valid = v; r.op = op; r.addr = a; r.wdata = d; r.exp_old = e;
    return r;
  endfunction

  initial begin
    rst = 1'b0; pc_x = 32'd0; instr_valid = 1'b0; csr_op = CSR_NONE;
    csr_addr = 12'd0; csr_wdata = 32'd0; is_mret = 1'b0;
    timer_irq = 1'b0; ext_irq = 1'b0;

    vecs.push_back(mk(1, CSR_RW,   ADDR_MTVEC,   32'h0000_0100, RST_VEC));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MTVEC,   32'h0,         32'h0000_0100));
    vecs.push_back(mk(0, CSR_RW,   ADDR_MTVEC,   32'h0000_0999, 32'h0000_0100));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MTVEC,   32'h0,         32'h0000_0100));
    vecs.push_back(mk(1, CSR_RW,   ADDR_MEPC,    32'h0000_0123, 32'h0));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MEPC,    32'h0,         32'h0000_0120));
    vecs.push_back(mk(1, CSR_RS,   ADDR_MSTATUS, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(1, CSR_RC,   ADDR_MSTATUS, 32'h0000_0008, 32'h0000_0088));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MSTATUS, 32'h0,         32'h0000_0080));
    vecs.push_back(mk(1, CSR_RW,   ADDR_MIE,     32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(1, CSR_RC,   ADDR_MIE,     32'h0000_0800, 32'h0000_0880));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MIE,     32'h0,         32'h0000_0080));
    vecs.push_back(mk(1, CSR_RW,   ADDR_MIP,     32'h0000_FFFF, 32'h0));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MIP,     32'h0,         32'h0));
    vecs.push_back(mk(1, CSR_RW,   12'h7C0,      32'h0000_DEAD, 32'h0));
    vecs.push_back(mk(1, CSR_NONE, 12'h7C0,      32'h0,         32'h0));
    vecs.push_back(mk(1, CSR_RW,   ADDR_MCAUSE,  32'h8000_0005, 32'h0));
    vecs.push_back(mk(1, CSR_RS,   ADDR_MCAUSE,  32'h0000_0002, 32'h8000_0005));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MCAUSE,  32'h0,         32'h8000_0007));
    vecs.push_back(mk(1, CSR_RW,   ADDR_MSTATUS, 32'h0,         32'h0000_0080));
    vecs.push_back(mk(1, CSR_NONE, ADDR_MSTATUS, 32'h0,         32'h0));
    vecs.push_back(mk(1, CSR_RW,   ADDR_MIE,     32'h0,         32'h0000_0080));

    // ---------------- reset state ----------------
    do_reset();
    check("rst_epc", {31'd0, csr_epc_taken}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_evec", csr_evec, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, ST_RUN});
    rd("rst_mstatus", ADDR_MSTATUS, 32'd0);
    rd("rst_mepc", ADDR_MEPC, 32'd0);

    // ---------------- table: CSR read/modify/write ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      instr_valid = vecs[i].valid;
      csr_op      = vecs[i].op;
      csr_addr    = vecs[i].addr;
      csr_wdata   = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_old);
      check($sformatf("vec%0d_epc", i), {31'd0, csr_epc_taken}, 32'd0);
      tick();
    end
    csr_op = CSR_NONE;
    instr_valid = 1'b1;

    // ---------------- timer trap, direct mode ----------------
    do_reset();
    csr_w(CSR_RW, ADDR_MTVEC, 32'h0000_0100);
    csr_w(CSR_RW, ADDR_MIE, 32'h0000_0080);
    csr_w(CSR_RW, ADDR_MSTATUS, 32'h0000_0008);
    pc_x = 32'h40; timer_irq = 1'b1;
    tick();
    check("trap_epc", {31'd0, csr_epc_taken}, 32'd1);
    check("trap_flush", {31'd0, flush}, 32'd1);
    check("trap_evec", csr_evec, 32'h100);
    check("trap_state", {30'd0, fsm_state}, {30'd0, ST_TRAP});
    rd("trap_mepc", ADDR_MEPC, 32'h40);
    rd("trap_mcause", ADDR_MCAUSE, CAUSE_M_TIMER);
    rd("trap_mstatus", ADDR_MSTATUS, 32'h80);
    // a CSR write and MRET in the redirect cycle must be dropped
    csr_op = CSR_RW; csr_addr = ADDR_MTVEC; csr_wdata = 32'hABC; is_mret = 1'b1;
    tick();
    csr_op = CSR_NONE; is_mret = 1'b0;
    check("post_trap_epc", {31'd0, csr_epc_taken}, 32'd0);
    check("post_trap_evec", csr_evec, 32'd0);
    check("post_trap_state", {30'd0, fsm_state}, {30'd0, ST_RUN});
    rd("trap_wr_ignored", ADDR_MTVEC, 32'h100);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("no_nest", {31'd0, csr_epc_taken}, 32'd0);
    end

    // ---------------- MRET ----------------
    timer_irq = 1'b0; is_mret = 1'b1;
    tick();
    is_mret = 1'b0;
    check("mret_epc", {31'd0, csr_epc_taken}, 32'd1);
    check("mret_evec", csr_evec, 32'h40);
    check("mret_state", {30'd0, fsm_state}, {30'd0, ST_RETURN});
    rd("mret_mstatus", ADDR_MSTATUS, 32'h88);
    tick();
    check("post_mret_epc", {31'd0, csr_epc_taken}, 32'd0);

    // ---------------- vectored mode, external over timer ----------------
    csr_w(CSR_RW, ADDR_MTVEC, 32'h0000_0101);
    csr_w(CSR_RW, ADDR_MIE, 32'h0000_0880);
    pc_x = 32'h20; ext_irq = 1'b1; timer_irq = 1'b1;
    tick();
    check("vec_epc", {31'd0, csr_epc_taken}, 32'd1);
    check("vec_evec", csr_evec, 32'h12C);
    rd("vec_mcause", ADDR_MCAUSE, CAUSE_M_EXT);
    rd("vec_mepc", ADDR_MEPC, 32'h20);
    ext_irq = 1'b0; timer_irq = 1'b0;
    tick();

    // ---------------- mode 10 behaves as direct ----------------
    csr_w(CSR_RW, ADDR_MTVEC, 32'h0000_0102);
    csr_w(CSR_RW, ADDR_MSTATUS, 32'h0000_0008);
    pc_x = 32'h30; timer_irq = 1'b1;
    tick();
    check("mode2_evec", csr_evec, 32'h100);
    rd("mode2_mcause", ADDR_MCAUSE, CAUSE_M_TIMER);
    timer_irq = 1'b0;
    tick();

    // ---------------- trap beats CSR write and MRET ----------------
    csr_w(CSR_RW, ADDR_MSTATUS, 32'h0000_0008);
    pc_x = 32'h60; timer_irq = 1'b1;
    csr_op = CSR_RS; csr_addr = ADDR_MSTATUS; csr_wdata = 32'h8; is_mret = 1'b1;
    tick();
    csr_op = CSR_NONE; is_mret = 1'b0;
    check("coll_epc", {31'd0, csr_epc_taken}, 32'd1);
    check("coll_evec", csr_evec, 32'h100);
    rd("coll_mstatus", ADDR_MSTATUS, 32'h80);
    rd("coll_mepc", ADDR_MEPC, 32'h60);
    timer_irq = 1'b0;
    tick();

    // ---------------- CSRRC mie disables timer ----------------
    csr_w(CSR_RC, ADDR_MIE, 32'h0000_0080);
    csr_w(CSR_RW, ADDR_MSTATUS, 32'h0000_0008);
    timer_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mtie_off", {31'd0, csr_epc_taken}, 32'd0);
    end
    timer_irq = 1'b0;

    // ---------------- bubble holds off the trap ----------------
    csr_w(CSR_RW, ADDR_MIE, 32'h0000_0080);
    instr_valid = 1'b0; timer_irq = 1'b1; pc_x = 32'h70;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bubble_no_trap", {31'd0, csr_epc_taken}, 32'd0);
    end
    instr_valid = 1'b1;
    tick();
    check("valid_trap", {31'd0, csr_epc_taken}, 32'd1);
    rd("valid_mepc", ADDR_MEPC, 32'h70);
    timer_irq = 1'b0;
    tick();

    // ---------------- reset during TRAP ----------------
    csr_w(CSR_RW, ADDR_MSTATUS, 32'h0000_0008);
    timer_irq = 1'b1;
    tick();
    check("pre_rst_trap", {31'd0, csr_epc_taken}, 32'd1);
    rst = 1'b0; timer_irq = 1'b0;
    tick();
    check("rst_trap_epc", {31'd0, csr_epc_taken}, 32'd0);
    check("rst_trap_flush", {31'd0, flush}, 32'd0);
    check("rst_trap_state", {30'd0, fsm_state}, {30'd0, ST_RUN});
    rd("rst_trap_mtvec", ADDR_MTVEC, RST_VEC);
    rd("rst_trap_mie", ADDR_MIE, 32'd0);
    rd("rst_trap_mepc", ADDR_MEPC, 32'd0);
    rd("rst_trap_mcause", ADDR_MCAUSE, 32'd0);
    rd("rst_trap_mstatus", ADDR_MSTATUS, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_trap_after", {31'd0, csr_epc_taken}, 32'd0);

    // ---------------- reset during RETURN ----------------
    is_mret = 1'b1;
    tick();
    check("pre_rst_ret", {30'd0, fsm_state}, {30'd0, ST_RETURN});
    rst = 1'b0; is_mret = 1'b0;
    tick();
    check("rst_ret_epc", {31'd0, csr_epc_taken}, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_ret_after", {31'd0, csr_epc_taken}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
